// File: rtl/cordic_sincos_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_sincos_ctrl_if
//  Description : Angle-request and cos/sin-result valid/ready streams
//  Revision    : 1.0  initial release
// ============================================================================
interface cordic_sincos_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_angle;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_cos;
    logic [WIDTH-1:0] out_sin;
    logic             out_err;

    modport master (
        output in_valid, in_angle, out_ready,
        input  in_ready, out_valid, out_cos, out_sin, out_err
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
        output in_ready, out_valid, out_cos, out_sin, out_err
    );
endinterface
`default_nettype wire

// File: rtl/cordic_sincos_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_sincos_ctrl
//  Description : Folds an angle into [-pi/2, pi/2], runs one circular rotation
//                job on the cordic core, fixes the cos sign, guards with timeout
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_sincos_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cordic_sincos_ctrl_if.slave   bus,
    output logic                  busy,
    output logic                  cor_enable,
    output logic                  cor_mode_op,
    output logic [1:0]            cor_mode_coord,
    output logic [WIDTH-1:0]      cor_x_in,
    output logic [WIDTH-1:0]      cor_y_in,
    output logic [WIDTH-1:0]      cor_z_in,
    input  wire logic [WIDTH-1:0] cor_x_out,
    input  wire logic [WIDTH-1:0] cor_y_out,
    input  wire logic             cor_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int                      c_TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_TW-1:0]         c_TLAST    = c_TW'(TIMEOUT - 1);
    localparam logic signed [WIDTH-1:0] c_PI       = WIDTH'(205887);
    localparam logic signed [WIDTH-1:0] c_NEG_PI   = -c_PI;
    localparam logic signed [WIDTH-1:0] c_HALF     = WIDTH'(102944);
    localparam logic signed [WIDTH-1:0] c_NEG_HALF = -c_HALF;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_cor_enable;
    logic [WIDTH-1:0]        r_cos;
    logic [WIDTH-1:0]        r_sin;
    logic                    r_err;
    logic signed [WIDTH-1:0] r_z;
    logic                    r_neg;
    logic [c_TW-1:0]         r_timer;

    logic signed [WIDTH-1:0] w_angle;
    logic signed [WIDTH-1:0] w_z;
    logic                    w_neg;
    logic                    w_range_err;
    logic                    w_accept;
    logic                    w_timeout;

    assign w_angle     = bus.in_angle;
    assign w_range_err = (w_angle > c_PI) || (w_angle < c_NEG_PI);
    assign w_accept    = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
    assign w_timeout   = (r_timer == c_TLAST);

    // Reflect outer-half-plane angles about +/-pi/2: sin is preserved, cos flips sign.
    always_comb begin
        w_z   = w_angle;
        w_neg = 1'b0;
        if (w_angle > c_HALF) begin
            w_z   = c_PI - w_angle;
            w_neg = 1'b1;
        end else if (w_angle < c_NEG_HALF) begin
            w_z   = c_NEG_PI - w_angle;
            w_neg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_range_err ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (cor_valid || w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // in_ready stays low for the first IDLE cycle after a result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_cor_enable <= 1'b0;
            r_cos        <= '0;
            r_sin        <= '0;
            r_err        <= 1'b0;
            r_z          <= '0;
            r_neg        <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_in_ready   <= (w_state_next == S_IDLE) && (r_state == S_IDLE);
            r_out_valid  <= (w_state_next == S_DONE);
            r_cor_enable <= (w_state_next == S_ISSUE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_range_err) begin
                            r_cos <= '0;
                            r_sin <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_z   <= w_z;
                            r_neg <= w_neg;
                        end
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    r_timer <= r_timer + c_TW'(1);
                    // A result arriving on the timeout cycle is still taken.
                    if (cor_valid) begin
                        r_cos <= r_neg ? -cor_x_out : cor_x_out;
                        r_sin <= cor_y_out;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_cos <= '0;
                        r_sin <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_cos    = r_cos;
    assign bus.out_sin    = r_sin;
    assign bus.out_err    = r_err;
    assign busy           = (r_state != S_IDLE);
    assign cor_enable     = r_cor_enable;
    assign cor_mode_op    = 1'b0;
    assign cor_mode_coord = 2'b01;
    assign cor_x_in       = WIDTH'(65536);
    assign cor_y_in       = '0;
    assign cor_z_in       = r_z;

endmodule
`default_nettype wire
